// File: rtl/data_ram_ctrl_pkg.sv
// Shared definitions for the MA-stage data RAM controller: access sizes,
// byte-lane enable generation and the alignment rule.
package data_ram_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] en;
    case (size)
      SZ_BYTE: en = 4'b0001 << off;
      SZ_HALF: en = off[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  // Size 3 is never a legal access and is treated like any other misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00)) ||
           (size == 2'd3);
  endfunction

endpackage

// File: rtl/data_ram_ctrl_load_align.sv
// Combinational load alignment: picks a byte or half-word out of a RAM word by
// byte offset and zero- or sign-extends it to 32 bits.
module data_ram_ctrl_load_align
  import data_ram_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{~uns & half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM port controller: per-port CPU/monitor arbitration with a bounded
// monitor wait, store lane building, load alignment and write-to-read forwarding.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int DRWIDTH      = 12,
  parameter int MON_MAX_WAIT = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_re,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_adr,
  input  logic [1:0]         cpu_size,
  input  logic               cpu_unsigned,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_rvalid,
  output logic               cpu_stall,
  output logic               cpu_misalign,
  input  logic               mon_re,
  input  logic               mon_we,
  input  logic [DRWIDTH-1:0] mon_adr,
  input  logic [31:0]        mon_wdata,
  output logic               mon_gnt,
  output logic [31:0]        mon_rdata,
  output logic               mon_rvalid,
  output logic [DRWIDTH-1:0] ram_radr,
  output logic [DRWIDTH-1:0] ram_wadr,
  input  logic [31:0]        ram_rdata,
  output logic [31:0]        ram_wdata,
  output logic [3:0]         ram_wen
);

  localparam logic [3:0] MAX_WAIT = 4'(MON_MAX_WAIT);

  logic [DRWIDTH-1:0] cpu_word;
  logic [1:0]         cpu_off;
  logic               mis;
  logic               cpu_rd_req, cpu_wr_req, mon_req;
  logic               conflict, mon_force;
  logic               cpu_rd_go, cpu_wr_go, mon_rd_go, mon_wr_go;
  logic               rd_go, wr_go, fwd_hit;
  logic [3:0]         wait_cnt;
  logic [DRWIDTH-1:0] radr_q;
  logic [1:0]         off_q, size_q;
  logic               uns_q;
  logic [3:0]         fwd_wen_q;
  logic [31:0]        fwd_data_q;
  logic [31:0]        merged;
  logic               unused_adr;

  assign cpu_word   = cpu_adr[DRWIDTH+1:2];
  assign cpu_off    = cpu_adr[1:0];
  assign unused_adr = ^cpu_adr[31:DRWIDTH+2];

  assign mis        = (cpu_re | cpu_we) & misaligned(cpu_size, cpu_off);
  assign cpu_rd_req = cpu_re & ~mis;
  assign cpu_wr_req = cpu_we & ~mis;
  assign mon_req    = mon_re | mon_we;

  // Loads and stores occupy different RAM ports, so the monitor only collides
  // with the CPU when it needs the same port.
  assign conflict   = (mon_re & cpu_rd_req) | (mon_we & cpu_wr_req);
  assign mon_force  = conflict & (wait_cnt == MAX_WAIT);
  assign mon_gnt    = mon_req & (~conflict | mon_force);
  assign cpu_stall  = mon_force;

  assign cpu_rd_go  = cpu_rd_req & ~mon_force;
  assign cpu_wr_go  = cpu_wr_req & ~mon_force;
  assign mon_rd_go  = mon_re & mon_gnt;
  assign mon_wr_go  = mon_we & mon_gnt;
  assign rd_go      = cpu_rd_go | mon_rd_go;
  assign wr_go      = cpu_wr_go | mon_wr_go;

  always_comb begin
    ram_radr = radr_q;
    if (cpu_rd_go) begin
      ram_radr = cpu_word;
    end else if (mon_rd_go) begin
      ram_radr = mon_adr;
    end
  end

  always_comb begin
    ram_wadr  = cpu_word;
    ram_wen   = 4'b0000;
    ram_wdata = cpu_wdata;
    if (cpu_wr_go) begin
      ram_wen = lane_en(cpu_size, cpu_off);
      case (cpu_size)
        SZ_BYTE: ram_wdata = {4{cpu_wdata[7:0]}};
        SZ_HALF: ram_wdata = {2{cpu_wdata[15:0]}};
        default: ram_wdata = cpu_wdata;
      endcase
    end else if (mon_wr_go) begin
      ram_wadr  = mon_adr;
      ram_wen   = 4'b1111;
      ram_wdata = mon_wdata;
    end
  end

  // Same-word write and read in one cycle: remember the written lanes so the
  // returned word never depends on the RAM's collision behaviour.
  assign fwd_hit = rd_go & wr_go & (ram_wadr == ram_radr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      radr_q       <= '0;
      off_q        <= 2'b00;
      size_q       <= SZ_WORD;
      uns_q        <= 1'b0;
      cpu_rvalid   <= 1'b0;
      mon_rvalid   <= 1'b0;
      cpu_misalign <= 1'b0;
      fwd_wen_q    <= 4'b0000;
      fwd_data_q   <= '0;
      wait_cnt     <= 4'd0;
    end else begin
      radr_q       <= ram_radr;
      cpu_rvalid   <= cpu_rd_go;
      mon_rvalid   <= mon_rd_go;
      cpu_misalign <= mis;
      if (cpu_rd_go) begin
        off_q  <= cpu_off;
        size_q <= cpu_size;
        uns_q  <= cpu_unsigned;
      end
      fwd_wen_q <= fwd_hit ? ram_wen : 4'b0000;
      if (fwd_hit) begin
        fwd_data_q <= ram_wdata;
      end
      if (mon_gnt || !mon_req) begin
        wait_cnt <= 4'd0;
      end else if (conflict) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fwd_wen_q[i]) begin
        merged[8*i +: 8] = fwd_data_q[8*i +: 8];
      end
    end
  end

  assign mon_rdata = merged;

  data_ram_ctrl_load_align u_load_align (
    .word (merged),
    .off  (off_q),
    .size (size_q),
    .uns  (uns_q),
    .data (cpu_rdata)
  );

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl with a read-first behavioural RAM model.
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we, cpu_unsigned;
  logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_size;
  logic        cpu_rvalid, cpu_stall, cpu_misalign;
  logic        mon_re, mon_we, mon_gnt, mon_rvalid;
  logic [11:0] mon_adr, ram_radr, ram_wadr;
  logic [31:0] mon_wdata, mon_rdata, ram_rdata, ram_wdata;
  logic [3:0]  ram_wen;
  logic [31:0] mem [0:4095];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_ram_ctrl #(.DRWIDTH(12), .MON_MAX_WAIT(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall), .cpu_misalign(cpu_misalign),
    .mon_re(mon_re), .mon_we(mon_we), .mon_adr(mon_adr), .mon_wdata(mon_wdata),
    .mon_gnt(mon_gnt), .mon_rdata(mon_rdata), .mon_rvalid(mon_rvalid),
    .ram_radr(ram_radr), .ram_wadr(ram_wadr), .ram_rdata(ram_rdata),
    .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  // Read-first RAM: a same-cycle read of a word being written returns old data.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_radr];
    for (int i = 0; i < 4; i++)
      if (ram_wen[i]) mem[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
  end

  task automatic idle();
    cpu_re = 0; cpu_we = 0; cpu_adr = 0; cpu_size = 2; cpu_unsigned = 0; cpu_wdata = 0;
    mon_re = 0; mon_we = 0; mon_adr = 0; mon_wdata = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rvalid got %b exp 0", cpu_rvalid); end
    n_cmp++; if (mon_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_mon_rvalid got %b exp 0", mon_rvalid); end
    n_cmp++; if (cpu_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign got %b exp 0", cpu_misalign); end
    n_cmp++; if (ram_wen !== 4'b0000) begin n_err++; $display("FAIL rst_wen got %b exp 0000", ram_wen); end
    rst_n = 1;
    step();
  endtask

  task automatic test_store_load_byte();
    idle(); cpu_we = 1; cpu_adr = 32'h103; cpu_size = 0; cpu_wdata = 32'h000000A5;
    #1;
    n_cmp++; if (ram_wen !== 4'b1000) begin n_err++; $display("FAIL sb_wen got %b exp 1000", ram_wen); end
    n_cmp++; if (ram_wdata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_wdata got %h exp a5a5a5a5", ram_wdata); end
    n_cmp++; if (ram_wadr !== 12'h040) begin n_err++; $display("FAIL sb_wadr got %h exp 040", ram_wadr); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL sb_stall got %b exp 0", cpu_stall); end
    step();
    idle(); cpu_re = 1; cpu_adr = 32'h103; cpu_size = 0; cpu_unsigned = 1;
    #1;
    n_cmp++; if (ram_radr !== 12'h040) begin n_err++; $display("FAIL lbu_radr got %h exp 040", ram_radr); end
    n_cmp++; if (ram_wen !== 4'b0000) begin n_err++; $display("FAIL lbu_wen got %b exp 0000", ram_wen); end
    step();
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL lbu_rvalid got %b exp 1", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'h000000A5) begin n_err++; $display("FAIL lbu_rdata got %h exp 000000a5", cpu_rdata); end
    cpu_unsigned = 0;
    step();
    n_cmp++; if (cpu_rdata !== 32'hFFFFFFA5) begin n_err++; $display("FAIL lb_rdata got %h exp ffffffa5", cpu_rdata); end
    idle();
    step();
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL lb_rvalid_drop got %b exp 0", cpu_rvalid); end
  endtask

  task automatic test_fwd_mon();
    idle(); cpu_we = 1; cpu_adr = 32'h10; cpu_size = 2; cpu_wdata = 32'h12345678;
    mon_re = 1; mon_adr = 12'h004;
    #1;
    n_cmp++; if (mon_gnt !== 1'b1) begin n_err++; $display("FAIL fm_gnt got %b exp 1", mon_gnt); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL fm_stall got %b exp 0", cpu_stall); end
    n_cmp++; if (ram_wen !== 4'b1111) begin n_err++; $display("FAIL fm_wen got %b exp 1111", ram_wen); end
    step();
    idle();
    #1;
    n_cmp++; if (mon_rvalid !== 1'b1) begin n_err++; $display("FAIL fm_rvalid got %b exp 1", mon_rvalid); end
    n_cmp++; if (mon_rdata !== 32'h12345678) begin n_err++; $display("FAIL fm_rdata got %h exp 12345678", mon_rdata); end
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL fm_cpu_rvalid got %b exp 0", cpu_rvalid); end
    step();
  endtask

  task automatic test_misalign();
    idle(); cpu_re = 1; cpu_adr = 32'h201; cpu_size = 1;
    #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL mis_stall got %b exp 0", cpu_stall); end
    n_cmp++; if (ram_radr !== 12'h004) begin n_err++; $display("FAIL mis_radr_hold got %h exp 004", ram_radr); end
    step();
    idle();
    #1;
    n_cmp++; if (cpu_misalign !== 1'b1) begin n_err++; $display("FAIL mis_flag got %b exp 1", cpu_misalign); end
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL mis_rvalid got %b exp 0", cpu_rvalid); end
    step();
    n_cmp++; if (cpu_misalign !== 1'b0) begin n_err++; $display("FAIL mis_flag_clear got %b exp 0", cpu_misalign); end
    cpu_we = 1; cpu_adr = 32'h206; cpu_size = 2;
    #1;
    n_cmp++; if (ram_wen !== 4'b0000) begin n_err++; $display("FAIL mis_sw_wen got %b exp 0000", ram_wen); end
    step();
    idle();
    step();
  endtask

  task automatic test_starvation();
    idle(); cpu_re = 1; cpu_adr = 32'h0; cpu_size = 2; mon_re = 1; mon_adr = 12'h005;
    for (int c = 1; c <= 9; c++) begin
      #1;
      if (c <= 7) begin
        n_cmp++; if (mon_gnt !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_c%0d gnt %b stall %b exp 0 0", c, mon_gnt, cpu_stall); end
      end else if (c == 8) begin
        n_cmp++; if (mon_gnt !== 1'b1 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL starve_force gnt %b stall %b exp 1 1", mon_gnt, cpu_stall); end
        n_cmp++; if (ram_radr !== 12'h005) begin n_err++; $display("FAIL starve_force_radr got %h exp 005", ram_radr); end
      end else begin
        n_cmp++; if (mon_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL starve_rvalid mon %b cpu %b exp 1 0", mon_rvalid, cpu_rvalid); end
        n_cmp++; if (mon_gnt !== 1'b0 || cpu_stall !== 1'b0 || ram_radr !== 12'h000) begin n_err++; $display("FAIL starve_cpu_after gnt %b stall %b radr %h exp 0 0 000", mon_gnt, cpu_stall, ram_radr); end
      end
      #1;
      step();
    end
    idle();
    step();
  endtask

  task automatic test_half_fwd();
    idle(); mon_we = 1; mon_adr = 12'h0C0; mon_wdata = 32'h11223344;
    step();
    idle(); cpu_we = 1; cpu_adr = 32'h302; cpu_size = 1; cpu_wdata = 32'h0000BEEF;
    mon_re = 1; mon_adr = 12'h0C0;
    #1;
    n_cmp++; if (ram_wen !== 4'b1100 || ram_wdata !== 32'hBEEFBEEF) begin n_err++; $display("FAIL sh_lanes wen %b wdata %h exp 1100 beefbeef", ram_wen, ram_wdata); end
    step();
    idle(); cpu_re = 1; cpu_adr = 32'h300; cpu_size = 2;
    #1;
    n_cmp++; if (mon_rdata !== 32'hBEEF3344) begin n_err++; $display("FAIL sh_fwd_mon got %h exp beef3344", mon_rdata); end
    step();
    n_cmp++; if (cpu_rdata !== 32'hBEEF3344) begin n_err++; $display("FAIL sh_cpu_next got %h exp beef3344", cpu_rdata); end
    idle(); cpu_re = 1; cpu_adr = 32'h300; cpu_size = 2;
    mon_we = 1; mon_adr = 12'h0C0; mon_wdata = 32'hCAFEF00D;
    step();
    n_cmp++; if (cpu_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL mw_fwd_cpu got %h exp cafef00d", cpu_rdata); end
    idle(); cpu_re = 1; cpu_adr = 32'h302; cpu_size = 1; cpu_unsigned = 0;
    step();
    n_cmp++; if (cpu_rdata !== 32'hFFFFCAFE) begin n_err++; $display("FAIL lh_signed got %h exp ffffcafe", cpu_rdata); end
    idle();
    step();
  endtask

  task automatic test_reset_mid_read();
    idle(); cpu_re = 1; cpu_adr = 32'h0; cpu_size = 2; mon_re = 1; mon_adr = 12'h001;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b1 || dut.wait_cnt !== 4'd3) begin n_err++; $display("FAIL pre_rst rvalid %b wait %0d exp 1 3", cpu_rvalid, dut.wait_cnt); end
    rst_n = 0;
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b0 || mon_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid rvalid cpu %b mon %b exp 0 0", cpu_rvalid, mon_rvalid); end
    n_cmp++; if (dut.wait_cnt !== 4'd0) begin n_err++; $display("FAIL rst_mid_wait got %0d exp 0", dut.wait_cnt); end
    idle();
    step();
    rst_n = 1;
    step();
    n_cmp++; if (cpu_rvalid !== 1'b0 || mon_rvalid !== 1'b0 || dut.wait_cnt !== 4'd0) begin n_err++; $display("FAIL post_rst rvalid %b %b wait %0d exp 0 0 0", cpu_rvalid, mon_rvalid, dut.wait_cnt); end
  endtask

  initial begin
    test_reset();
    test_store_load_byte();
    test_fwd_mon();
    test_misalign();
    test_starvation();
    test_half_fwd();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
